// File: rtl/conv_pkg.sv
// Shared constants and state type for the convolution window accumulator.
// Defaults: 6x6 image, 3x3 kernel, 8-bit signed data, 20-bit accumulator.
package conv_pkg;

  localparam int IMA_SIZE = 6;
  localparam int IMA_ADDR = 3;
  localparam int CON_SIZE = 3;
  localparam int CON_ADDR = 2;
  localparam int DATA_W   = 8;
  localparam int ACC_W    = 20;

  localparam int OUT_SIZE = IMA_SIZE - CON_SIZE + 1;
  localparam int TAPS     = CON_SIZE * CON_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_HOLD
  } conv_state_e;

endpackage

// File: rtl/conv_out_pos.sv
// Output feature-map raster position counter (col fastest, wraps to 0,0).
// Ports: clk, reset (async low), clr, adv -> row, col, last.
module conv_out_pos #(
  parameter int OUT_SIZE = 4,
  parameter int ADDR_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              adv,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  localparam logic [ADDR_W-1:0] MAXP =
    ADDR_W'(OUT_SIZE - 1);

  logic row_end;
  logic col_end;

  assign row_end = (row == MAXP);
  assign col_end = (col == MAXP);
  assign last    = row_end && col_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/conv_window_accum.sv
// Multiply-accumulates CON_SIZE^2 pixel/weight terms per window and emits
// each sum with its output-map position over valid/ready. Option: RELU_EN.
// Ports: clk, reset (async low), frame_en, in_valid/in_ready/in_pixel/
// in_weight, out_valid/out_ready/out_data/out_row/out_col/out_last.
module conv_window_accum #(
  parameter int IMA_SIZE = conv_pkg::IMA_SIZE,
  parameter int IMA_ADDR = conv_pkg::IMA_ADDR,
  parameter int CON_SIZE = conv_pkg::CON_SIZE,
  parameter int CON_ADDR = conv_pkg::CON_ADDR,
  parameter int DATA_W   = conv_pkg::DATA_W,
  parameter int ACC_W    = conv_pkg::ACC_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     frame_en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_pixel,
  input  logic signed [DATA_W-1:0] in_weight,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [IMA_ADDR-1:0]      out_row,
  output logic [IMA_ADDR-1:0]      out_col,
  output logic                     out_last
);

  import conv_pkg::*;

  localparam int OUT_N = IMA_SIZE - CON_SIZE + 1;
  localparam int PW    = 2 * DATA_W;
  localparam logic [CON_ADDR-1:0] TAP_MAX =
    CON_ADDR'(CON_SIZE - 1);

  conv_state_e state;

  logic hold;
  logic clr;
  logic accept;
  logic first_tap;
  logic last_tap;
  logic done;

  logic [CON_ADDR-1:0] tap_row;
  logic [CON_ADDR-1:0] tap_col;

  logic signed [PW-1:0]    prod;
  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] res;

  logic [IMA_ADDR-1:0] pos_row;
  logic [IMA_ADDR-1:0] pos_col;
  logic                pos_last;

  assign hold = out_valid && !out_ready;

  always_comb begin
    state = ST_IDLE;
    unique case (1'b1)
      !frame_en:          state = ST_IDLE;
      frame_en && hold:   state = ST_HOLD;
      frame_en && !hold:  state = ST_ACCUM;
      default:            state = ST_IDLE;
    endcase
  end

  assign in_ready = (state == ST_ACCUM);
  assign clr      = (state == ST_IDLE);

  assign accept    = in_valid && in_ready;
  assign first_tap = (tap_row == '0) && (tap_col == '0);
  assign last_tap  = (tap_row == TAP_MAX) && (tap_col == TAP_MAX);
  assign done      = accept && last_tap;

  assign prod     = in_pixel * in_weight;
  assign prod_ext = {{(ACC_W-PW){prod[PW-1]}}, prod};
  assign sum      = (first_tap ? '0 : acc) + prod_ext;

`ifdef RELU_EN
  assign res = sum[ACC_W-1] ? '0 : sum;
`else
  assign res = sum;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tap_row <= '0;
      tap_col <= '0;
      acc     <= '0;
    end else if (clr) begin
      tap_row <= '0;
      tap_col <= '0;
      acc     <= '0;
    end else if (accept) begin
      acc <= sum;
      if (tap_col == TAP_MAX) begin
        tap_col <= '0;
        tap_row <= (tap_row == TAP_MAX) ? '0 : tap_row + 1'b1;
      end else begin
        tap_col <= tap_col + 1'b1;
      end
    end
  end

  // A completing window reloads even if the old result pops this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_last  <= 1'b0;
    end else if (done) begin
      out_valid <= 1'b1;
      out_data  <= res;
      out_row   <= pos_row;
      out_col   <= pos_col;
      out_last  <= pos_last;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  conv_out_pos #(
    .OUT_SIZE (OUT_N),
    .ADDR_W   (IMA_ADDR)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .adv   (done),
    .row   (pos_row),
    .col   (pos_col),
    .last  (pos_last)
  );

endmodule

// File: tb/tb_conv_window_accum.sv
// Randomised and directed bench for conv_window_accum with a
// window-level reference model.
module tb_conv_window_accum;

  localparam int OUT  = 4;
  localparam int TAPS = 9;

  logic clk = 1'b0;
  logic reset;
  logic frame_en;
  logic in_valid;
  logic in_ready;
  logic signed [7:0] in_pixel;
  logic signed [7:0] in_weight;
  logic out_valid;
  logic out_ready;
  logic signed [19:0] out_data;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic out_last;

  always #5 clk = ~clk;

  conv_window_accum dut (
    .clk       (clk),
    .reset     (reset),
    .frame_en  (frame_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pixel  (in_pixel),
    .in_weight (in_weight),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(string nm, logic signed [63:0] act,
                              logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic signed [19:0] d;
    int r;
    int c;
    bit l;
  } res_t;

  res_t q[$];
  longint wsum = 0;
  int nterm = 0;
  int wcnt = 0;
  int cyc = 0;

  int dpops = 0;
  int dlasts = 0;
  logic signed [19:0] dl_d;
  int dl_r;
  int dl_c;
  int dl_l;

  always @(posedge clk) cyc++;

  function automatic logic signed [19:0] clamp(longint s);
    logic signed [19:0] v;
    v = s[19:0];
`ifdef RELU_EN
    if (v < 0) v = '0;
`endif
    return v;
  endfunction

  always @(negedge clk) begin
    bit exp_ir;
    res_t r;
    int k;
    if (!reset) begin
      q.delete();
      wsum = 0;
      nterm = 0;
      wcnt = 0;
      chk("rst_ov", out_valid, 0);
    end else begin
      exp_ir = frame_en && !(q.size() > 0 && !out_ready);
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, q.size() > 0);
      if (out_valid && out_ready) begin
        dpops++;
        if (out_last) dlasts++;
        dl_d = out_data;
        dl_r = out_row;
        dl_c = out_col;
        dl_l = out_last;
      end
      if (q.size() > 0) begin
        chk("out_data", out_data, q[0].d);
        chk("out_row", out_row, q[0].r);
        chk("out_col", out_col, q[0].c);
        chk("out_last", out_last, q[0].l);
        if (out_ready) void'(q.pop_front());
      end
      if (!frame_en) begin
        wsum = 0;
        nterm = 0;
        wcnt = 0;
      end else if (in_valid && exp_ir) begin
        wsum += longint'(in_pixel) * longint'(in_weight);
        nterm++;
        if (nterm == TAPS) begin
          k = wcnt % (OUT * OUT);
          r.d = clamp(wsum);
          r.r = k / OUT;
          r.c = k % OUT;
          r.l = (k == OUT * OUT - 1);
          q.push_back(r);
          wcnt++;
          nterm = 0;
          wsum = 0;
        end
      end
    end
  end

  task automatic send(input logic signed [7:0] p,
                      input logic signed [7:0] w);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_pixel = p;
    in_weight = w;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin
        chk("in_timeout", in_ready, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int t;
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("ov_seen", out_valid, 1);
  endtask

  task automatic chk_out(string nm, longint d, int r, int c);
    chk({nm, "_d"}, out_data, d);
    chk({nm, "_r"}, out_row, r);
    chk({nm, "_c"}, out_col, c);
  endtask

  initial begin
    int c0;
    logic signed [19:0] hd;
    reset = 1'b0;
    frame_en = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_pixel = '0;
    in_weight = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk_out("rst", 0, 0, 0);
    chk("rst_last", out_last, 0);
    chk("rst_ir", in_ready, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;

    frame_en = 1'b1;
    out_ready = 1'b1;
    dpops = 0;
    dlasts = 0;
    c0 = cyc;
    for (int i = 0; i < 16 * TAPS; i++) send(8'sd1, 8'sd1);
    chk("throughput", cyc - c0, 16 * TAPS);
    repeat (2) @(posedge clk);
    #1;
    chk("ones_pops", dpops, 16);
    chk("ones_lasts", dlasts, 1);
    chk("ones_d", dl_d, 9);
    chk("ones_r", dl_r, 3);
    chk("ones_c", dl_c, 3);
    chk("ones_l", dl_l, 1);

    out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send(-8'sd2, 8'sd3);
    wait_ov();
`ifdef RELU_EN
    chk_out("neg", 0, 0, 0);
`else
    chk_out("neg", -54, 0, 0);
`endif
    hd = out_data;
    in_valid = 1'b1;
    in_pixel = 8'sd5;
    in_weight = -8'sd7;
    repeat (5) begin
      @(negedge clk);
      chk("hold_ir", in_ready, 0);
      chk("hold_d", out_data, hd);
      chk("hold_c", out_col, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'sd5, -8'sd7);
    out_ready = 1'b0;
    for (int i = 0; i < TAPS - 1; i++) send(8'sd4, 8'sd4);
    wait_ov();
    chk_out("resume", 93, 0, 1);

    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      send(8'($urandom), 8'($urandom));
    @(posedge clk);
    #1;
    frame_en = 1'b0;
    @(posedge clk);
    #1;
    frame_en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send(8'sd2, 8'sd2);
    wait_ov();
    chk_out("fdrop", 36, 0, 0);

    out_ready = 1'b1;
    send(-8'sd128, -8'sd128);
    out_ready = 1'b0;
    for (int i = 0; i < TAPS - 1; i++) send(-8'sd128, -8'sd128);
    wait_ov();
    chk_out("ext", 147456, 0, 1);
    out_ready = 1'b1;

    repeat (3000) begin
      @(posedge clk);
      #1;
      frame_en = ($urandom_range(0, 399) != 0);
      in_valid = ($urandom_range(0, 3) != 0);
      in_pixel = 8'($urandom);
      in_weight = 8'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
    end

    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    frame_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    frame_en = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < TAPS; i++) send(8'sd3, 8'sd1);
    wait_ov();
    chk_out("pre_rst", 27, 0, 0);
    in_valid = 1'b1;
    in_pixel = 8'sd1;
    in_weight = 8'sd1;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk_out("arst", 0, 0, 0);
    chk("arst_last", out_last, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int i = 0; i < TAPS; i++) send(8'sd1, 8'sd1);
    wait_ov();
    chk_out("post_rst", 9, 0, 0);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
